// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the CE222 PC/fetch sequencer: state encoding,
// next-PC source codes, opcode constants and the instruction classifier.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        PCSEL_SEQ  = 2'b00,
        PCSEL_BR   = 2'b01,
        PCSEL_JAL  = 2'b10,
        PCSEL_JALR = 2'b11
    } pc_sel_e;

    typedef enum logic [2:0] {
        CLS_SEQ    = 3'd0,
        CLS_BRANCH = 3'd1,
        CLS_JAL    = 3'd2,
        CLS_JALR   = 3'd3,
        CLS_ECALL  = 3'd4
    } instr_class_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Any SYSTEM-major opcode is treated as ECALL; everything unrecognised is sequential.
    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_SYSTEM: cls = CLS_ECALL;
            default:   cls = CLS_SEQ;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive FETCH cycles without an acknowledge; expired_o marks the
// last cycle in which an acknowledge is still accepted.
module fetch_timeout_ctr #(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(IMEM_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == LAST);

    // Saturate at LAST so the count can never wrap past the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/decode/execute/update sequencer for the CE222 core: drives
// instruction fetch, waits for branch resolution and strobes the PC write.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    seq_state_e       state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [1:0]       pc_sel_q, pc_sel_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             err_q, err_d;

    logic             in_fetch;
    logic             tmo_expired;
    instr_class_e     cls;

    assign in_fetch = (state_q == ST_FETCH);
    assign cls      = classify(instr_q[6:0]);

    // Counter is held clear whenever we are not waiting on the instruction memory.
    fetch_timeout_ctr #(
        .IMEM_TIMEOUT(IMEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (in_fetch && !imem_ack),
        .clr_i    (!in_fetch || imem_ack),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_sel_d  = pc_sel_q;
        instret_d = instret_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end

            ST_DECODE: begin
                if (!stall) begin
                    state_d = (cls == CLS_ECALL) ? ST_HALT : ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (!stall) begin
                    case (cls)
                        CLS_BRANCH: begin
                            if (br_valid) begin
                                pc_sel_d = br_taken ? PCSEL_BR : PCSEL_SEQ;
                                state_d  = ST_UPDATE;
                            end
                        end
                        CLS_JAL: begin
                            pc_sel_d = PCSEL_JAL;
                            state_d  = ST_UPDATE;
                        end
                        CLS_JALR: begin
                            pc_sel_d = PCSEL_JALR;
                            state_d  = ST_UPDATE;
                        end
                        default: begin
                            pc_sel_d = PCSEL_SEQ;
                            state_d  = ST_UPDATE;
                        end
                    endcase
                end
            end

            // run is only consulted here, so a dropped run lets the instruction retire.
            ST_UPDATE: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = run ? ST_FETCH : ST_IDLE;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            pc_sel_q  <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_sel_q  <= pc_sel_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign pc_we     = (state_q == ST_UPDATE);
    assign halted    = (state_q == ST_HALT);
    assign instr     = instr_q;
    assign pc_sel    = pc_sel_q;
    assign err       = err_q;
    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomised transaction bench for pc_fetch_sequencer; a second instance with a
// 4-bit retire counter shares the stimulus to exercise counter wrap-around.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] W_ADDI  = 32'h0050_0093;
    localparam logic [31:0] W_BEQ   = 32'h0020_8463;
    localparam logic [31:0] W_JAL   = 32'h0180_006F;
    localparam logic [31:0] W_JALR  = 32'h0000_8067;
    localparam logic [31:0] W_ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset, run, imem_ack, stall, br_valid, br_taken;
    logic [31:0] imem_rdata;

    logic        imem_req, pc_we, halted, err;
    logic [31:0] instr;
    logic [1:0]  pc_sel;
    logic [15:0] instret;
    logic [2:0]  state_dbg;

    logic        imem_req4, pc_we4, halted4, err4;
    logic [31:0] instr4;
    logic [1:0]  pc_sel4;
    logic [3:0]  instret4;
    logic [2:0]  state_dbg4;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_txn = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.IMEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .err(err),
        .instret(instret), .state_dbg(state_dbg)
    );

    pc_fetch_sequencer #(.IMEM_TIMEOUT(15), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .imem_req(imem_req4), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr4), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .pc_we(pc_we4), .pc_sel(pc_sel4), .halted(halted4), .err(err4),
        .instret(instret4), .state_dbg(state_dbg4)
    );

    // Reference: the architectural next-PC source an instruction word should produce.
    function automatic logic [1:0] model_pc_sel(input logic [31:0] w, input bit taken);
        case (w[6:0])
            7'h63:   return taken ? 2'd1 : 2'd0;
            7'h6F:   return 2'd2;
            7'h67:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic bit is_branch(input logic [31:0] w);
        return w[6:0] == 7'h63;
    endfunction

    function automatic bit is_ecall(input logic [31:0] w);
        return w[6:0] == 7'h73;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH to retirement. Expects the DUT to be in FETCH on entry.
    task automatic do_instr(input logic [31:0] w, input int ack_dly, input int dstall,
                            input int estall, input int br_dly, input bit taken,
                            input bit run_after);
        logic [1:0] esel;
        esel = model_pc_sel(w, taken);
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom; stall = 1'($urandom);
            br_valid = 1'($urandom); br_taken = 1'($urandom);
            n_vec++;
            if (state_dbg !== 3'd1 || imem_req !== 1'b1 || pc_we !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_wait cyc=%0d: state=%0d req=%b we=%b, required state=1 req=1 we=0", i, state_dbg, imem_req, pc_we);
            end
            step();
        end
        imem_ack = 1'b1; imem_rdata = w; stall = 1'($urandom);
        step();
        imem_ack = 1'b0; imem_rdata = $urandom;
        n_vec++;
        if (state_dbg !== 3'd2 || instr !== w || err !== 1'b0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL decode: state=%0d instr=%h err=%b req=%b, required state=2 instr=%h err=0 req=0", state_dbg, instr, err, imem_req, w);
        end
        for (int i = 0; i < dstall; i++) begin
            stall = 1'b1; br_valid = 1'($urandom); br_taken = 1'($urandom);
            step();
            n_vec++;
            if (state_dbg !== 3'd2) begin
                n_err++;
                $display("FAIL decode_stall: state=%0d, required 2", state_dbg);
            end
        end
        stall = 1'b0;
        step();
        br_valid = 1'b0;
        if (is_ecall(w)) begin
            n_vec++;
            if (state_dbg !== 3'd5 || halted !== 1'b1 || pc_we !== 1'b0 || instret !== exp_cnt) begin
                n_err++;
                $display("FAIL ecall_halt: state=%0d halted=%b we=%b instret=%0d, required 5 1 0 %0d", state_dbg, halted, pc_we, instret, exp_cnt);
            end
            n_txn++;
            $display("txn %0d word=%h ecall -> halt instret=%0d", n_txn, w, instret);
            return;
        end
        n_vec++;
        if (state_dbg !== 3'd3 || pc_we !== 1'b0) begin
            n_err++;
            $display("FAIL exec_entry: state=%0d we=%b, required state=3 we=0", state_dbg, pc_we);
        end
        for (int i = 0; i < estall; i++) begin
            stall = 1'b1; br_valid = 1'($urandom); br_taken = 1'($urandom);
            step();
            n_vec++;
            if (state_dbg !== 3'd3 || pc_we !== 1'b0) begin
                n_err++;
                $display("FAIL exec_stall: state=%0d we=%b, required state=3 we=0", state_dbg, pc_we);
            end
        end
        stall = 1'b0;
        if (is_branch(w)) begin
            for (int i = 0; i < br_dly; i++) begin
                br_valid = 1'b0; br_taken = 1'($urandom);
                step();
                n_vec++;
                if (state_dbg !== 3'd3 || pc_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL branch_wait: state=%0d we=%b, required state=3 we=0", state_dbg, pc_we);
                end
            end
            br_valid = 1'b1;
        end else begin
            br_valid = 1'b0;
        end
        br_taken = taken;
        step();
        br_valid = 1'b0; br_taken = 1'($urandom);
        n_vec++;
        if (state_dbg !== 3'd4 || pc_we !== 1'b1 || pc_sel !== esel || instret !== exp_cnt) begin
            n_err++;
            $display("FAIL update: state=%0d we=%b sel=%0d instret=%0d, required 4 1 %0d %0d", state_dbg, pc_we, pc_sel, instret, esel, exp_cnt);
        end
        run = run_after; stall = 1'($urandom);
        step();
        stall = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        n_vec++;
        if (state_dbg !== (run_after ? 3'd1 : 3'd0) || pc_we !== 1'b0 || pc_sel !== esel ||
            instret !== exp_cnt || instret4 !== exp_cnt[3:0] || state_dbg4 !== state_dbg) begin
            n_err++;
            $display("FAIL retire: state=%0d we=%b sel=%0d instret=%0d instret4=%0d st4=%0d, required state=%0d we=0 sel=%0d instret=%0d instret4=%0d",
                     state_dbg, pc_we, pc_sel, instret, instret4, state_dbg4, run_after ? 1 : 0, esel, exp_cnt, exp_cnt[3:0]);
        end
        n_txn++;
        $display("txn %0d word=%h pc_sel=%0d instret=%0d instret4=%0d", n_txn, w, pc_sel, instret, instret4);
        if (!run_after) begin
            step();
            n_vec++;
            if (state_dbg !== 3'd0 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL idle_park: state=%0d req=%b, required state=0 req=0", state_dbg, imem_req);
            end
            run = 1'b1;
            step();
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        step();
        step();
        n_vec++;
        if (state_dbg !== 3'd0 || instr !== 32'd0 || pc_sel !== 2'd0 || instret !== 16'd0 ||
            imem_req !== 1'b0 || pc_we !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d instr=%h sel=%0d instret=%0d req=%b we=%b halt=%b err=%b, required all zero",
                     state_dbg, instr, pc_sel, instret, imem_req, pc_we, halted, err);
        end
        reset = 1'b1;
        step();
        n_vec++;
        if (state_dbg !== 3'd0) begin
            n_err++;
            $display("FAIL idle_hold: state=%0d, required 0", state_dbg);
        end
        run = 1'b1;
        step();
        n_vec++;
        if (state_dbg !== 3'd1 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL idle_to_fetch: state=%0d req=%b, required state=1 req=1", state_dbg, imem_req);
        end
    endtask

    task automatic test_sequential();
        do_instr(W_ADDI, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_branch();
        do_instr(W_BEQ, 0, 0, 0, 3, 1'b1, 1'b1);
        do_instr(W_BEQ, 0, 0, 0, 3, 1'b0, 1'b1);
    endtask

    task automatic test_jumps();
        do_instr(W_JAL, 0, 0, 0, 0, 1'b0, 1'b1);
        do_instr(W_JALR, 0, 0, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: w = W_ADDI;
                1: w = W_BEQ;
                2: w = W_JAL;
                3: w = W_JALR;
                default: begin
                    w = $urandom;
                    if (w[6:0] == 7'h63 || w[6:0] == 7'h6F || w[6:0] == 7'h67 || w[6:0] == 7'h73)
                        w[6:0] = 7'h13;
                end
            endcase
            do_instr(w, $urandom_range(0, 14), $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_async_reset();
        imem_ack = 1'b1; imem_rdata = W_BEQ;
        step();
        imem_ack = 1'b0; br_valid = 1'b0;
        step();
        step();
        n_vec++;
        if (state_dbg !== 3'd3 || instret === 16'd0) begin
            n_err++;
            $display("FAIL pre_reset_exec: state=%0d instret=%0d, required state=3 instret nonzero", state_dbg, instret);
        end
        #2 reset = 1'b0;
        #1;
        exp_cnt = '0;
        n_vec++;
        if (state_dbg !== 3'd0 || pc_we !== 1'b0 || instret !== 16'd0 || instret4 !== 4'd0 ||
            instr !== 32'd0 || imem_req !== 1'b0 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset: state=%0d we=%b instret=%0d instret4=%0d instr=%h req=%b sel=%0d, required all zero",
                     state_dbg, pc_we, instret, instret4, instr, imem_req, pc_sel);
        end
        step();
        reset = 1'b1; run = 1'b1;
        step();
        n_vec++;
        if (state_dbg !== 3'd1) begin
            n_err++;
            $display("FAIL post_reset_fetch: state=%0d, required 1", state_dbg);
        end
    endtask

    task automatic test_timeout();
        imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if (state_dbg !== 3'd1 || imem_req !== 1'b1 || err !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_wait cyc=%0d: state=%0d req=%b err=%b, required 1 1 0", i + 1, state_dbg, imem_req, err);
            end
            stall = 1'($urandom);
            step();
        end
        stall = 1'b0;
        n_vec++;
        if (state_dbg !== 3'd5 || err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc_we !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_halt: state=%0d err=%b halt=%b req=%b we=%b, required 5 1 1 0 0", state_dbg, err, halted, imem_req, pc_we);
        end
        $display("txn timeout -> halt err=%b", err);
        apply_reset();
        step();
        n_vec++;
        if (state_dbg !== 3'd1 || err !== 1'b0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_recover: state=%0d err=%b halt=%b, required 1 0 0", state_dbg, err, halted);
        end
        do_instr(W_ADDI, 14, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_ecall();
        logic [15:0] frozen;
        frozen = exp_cnt;
        do_instr(W_ECALL, 1, 1, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom); imem_ack = 1'($urandom); imem_rdata = $urandom;
            br_valid = 1'($urandom); stall = 1'($urandom);
            step();
            n_vec++;
            if (state_dbg !== 3'd5 || halted !== 1'b1 || pc_we !== 1'b0 || imem_req !== 1'b0 ||
                instret !== frozen || err !== 1'b0) begin
                n_err++;
                $display("FAIL halt_hold: state=%0d halt=%b we=%b req=%b instret=%0d err=%b, required 5 1 0 0 %0d 0",
                         state_dbg, halted, pc_we, imem_req, instret, err, frozen);
            end
        end
        run = 1'b0; imem_ack = 1'b0; br_valid = 1'b0; stall = 1'b0;
        apply_reset();
        n_vec++;
        if (state_dbg !== 3'd0 || halted !== 1'b0 || instret !== 16'd0) begin
            n_err++;
            $display("FAIL halt_exit: state=%0d halt=%b instret=%0d, required 0 0 0", state_dbg, halted, instret);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jumps();
        test_random();
        test_async_reset();
        test_timeout();
        test_ecall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required finish before 400000");
        $fatal(1);
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle control FSM that sequences the ProgramCounter and instruction fetch for the CE222 core.
- Issues instruction-memory requests and latches the returned instruction.
- Classifies the instruction as sequential, branch, JAL, JALR or ECALL.
- Waits for branch resolution from the ALU, then issues a one-cycle PC write with a next-PC source select.
- Also counts retired instructions and flags fetch timeouts.

Parameters:
IMEM_TIMEOUT, 15, max FETCH cycles without imem_ack before error halt (>=1)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level enable; sequencing proceeds while high
imem_req  out  1  fetch request; high throughout FETCH state
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  latched current instruction, to decoder/datapath
stall  in  1  datapath hazard hold
br_valid  in  1  ALU branch compare result valid
br_taken  in  1  ALU branch compare result, sampled with br_valid
pc_we  out  1  one-cycle PC update strobe
pc_sel  out  2  next-PC source: 00 PC+4, 01 PC+branch offset, 10 PC+JAL offset, 11 rs1+imm (JALR)
halted  out  1  sequencer in HALT
err  out  1  fetch timeout occurred
instret  out  CNT_W  retired-instruction count
state_dbg  out  3  current state encoding

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - instr, pc_sel, instret and timeout counter go to 0.
  - imem_req, pc_we, halted and err go to 0.
  - Holds as long as reset=0.
- IDLE: go to FETCH when run=1; else stay.
- FETCH:
  - imem_req=1.
  - On imem_ack=1: latch imem_rdata into instr, clear timeout counter, go to DECODE next cycle.
  - Otherwise increment the timeout counter.
  - When IMEM_TIMEOUT consecutive FETCH cycles pass with no ack: go to HALT with err=1.
  - An ack in the last allowed cycle (cycle IMEM_TIMEOUT) is accepted.
- DECODE:
  - Classify on instr[6:0]: 1100011 branch, 1101111 JAL, 1100111 JALR, 1110011 ECALL, other sequential.
  - stall=1 holds DECODE.
  - ECALL goes to HALT; all other classes go to EXEC.
- EXEC:
  - stall=1 holds EXEC.
  - Branch: wait in EXEC until br_valid=1. Register pc_sel=01 if br_taken, else 00. br_valid ignored outside EXEC.
  - JAL: pc_sel=10. JALR: pc_sel=11. Sequential: pc_sel=00. None of these wait on br_valid.
  - Then go to UPDATE.
- UPDATE:
  - pc_we=1 for exactly this one cycle; pc_sel stable.
  - instret increments on the same edge, wrapping modulo 2^CNT_W.
  - Next state FETCH if run=1, else IDLE.
- run=0 mid-instruction does not abort; the instruction completes and the FSM parks in IDLE after UPDATE.
- HALT:
  - halted=1; imem_req=0, pc_we=0.
  - instret frozen; err holds its value.
  - Only reset exits HALT.
- Minimum latency: 4 cycles per non-stalled instruction with same-cycle ack (FETCH, DECODE, EXEC, UPDATE).
- stall=1 during FETCH or UPDATE has no effect.
- pc_we is never asserted outside UPDATE.
- All outputs are registered except imem_req, pc_we and halted, which are decoded from state.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, HALT=5
  - pc_sel codes PCSEL_SEQ/BR/JAL/JALR
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM
- One natural sub-module: fetch_timeout_ctr, which counts and compares against IMEM_TIMEOUT and reports an expired flag.
- The FSM and instret counter stay in the top module.

Test Plan:
1. Sequential: run=1, addi 0x00500093 with same-cycle ack → DECODE, EXEC, UPDATE follow on consecutive cycles; pc_we pulses 1 cycle with pc_sel=00; instret=1.
2. Branch: beq 0x00208463, br_valid held 0 for 3 EXEC cycles, then br_valid=1 and br_taken=1 → EXEC lasts 4 cycles, pc_sel=01 at UPDATE. Repeat with br_taken=0 → pc_sel=00.
3. Jumps: JAL 0x0180006F → pc_sel=10; JALR 0x00008067 → pc_sel=11. Neither waits on br_valid (br_valid=0 throughout); instret increments by 2.
4. Timeout: imem_ack never asserted → after 15 FETCH cycles, err=1, halted=1, imem_req=0. Ack arriving on cycle 15 instead → normal DECODE, err=0.
5. ECALL 0x00000073 → HALT with no pc_we and instret unchanged. run toggling has no effect; reset low→high returns to IDLE with halted=0.
6. Asynchronous reset asserted mid-EXEC of a branch → pc_we, instret and instr go to 0 immediately and state_dbg=0. Separately, with CNT_W=4, 16 retirements → instret wraps to 0.
